// File: rtl/mul_shiftadd_if.sv
// rtl/mul_shiftadd_if.sv - operand/result bundle for the shift-and-add multiplier
interface mul_shiftadd_if #(
    parameter int DATA_W = 32
);
    logic                  en;
    logic                  sign;
    logic                  done;
    logic [DATA_W-1:0]     multiplicand;
    logic [DATA_W-1:0]     multiplier;
    logic [2*DATA_W-1:0]   product;

    // Requester side: drives the run request and operands, reads the result.
    modport master (
        output en,
        output sign,
        output multiplicand,
        output multiplier,
        input  done,
        input  product
    );

    // Multiplier side.
    modport slave (
        input  en,
        input  sign,
        input  multiplicand,
        input  multiplier,
        output done,
        output product
    );
endinterface

// File: rtl/mul_shiftadd.sv
// rtl/mul_shiftadd.sv - iterative shift-and-add multiplier, signed or unsigned
module mul_shiftadd #(
    parameter int DATA_W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    mul_shiftadd_if.slave bus
);
    // pc must reach DATA_W+2 (HOLD); one spare bit keeps the compare simple.
    localparam int PC_W  = $clog2(DATA_W + 3) + 1;
    // Accumulator: hi part DATA_W+1 bits (carry included), lo part DATA_W bits.
    localparam int ACC_W = 2 * DATA_W + 1;

    localparam logic [PC_W-1:0] PC_LOAD      = '0;
    localparam logic [PC_W-1:0] PC_LAST_ITER = PC_W'(DATA_W);
    localparam logic [PC_W-1:0] PC_SIGN      = PC_W'(DATA_W + 1);
    localparam logic [PC_W-1:0] PC_HOLD      = PC_W'(DATA_W + 2);

    logic [PC_W-1:0]       pc;
    logic [PC_W-1:0]       pc_next;
    logic                  do_load;
    logic                  do_iter;
    logic                  do_sign;

    logic [DATA_W-1:0]     a_mag;
    logic                  neg_res;
    logic [ACC_W-1:0]      acc;
    logic [2*DATA_W-1:0]   product_r;
    logic                  done_r;

    logic [DATA_W-1:0]     a_mag_in;
    logic [DATA_W-1:0]     b_mag_in;
    logic                  neg_res_in;
    logic [DATA_W:0]       hi_sum;
    logic [ACC_W-1:0]      acc_step;
    logic [2*DATA_W-1:0]   acc_lo;
    logic [2*DATA_W-1:0]   product_fix;

    // State register: the step counter, cleared asynchronously by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc <= PC_LOAD;
        end else begin
            pc <= pc_next;
        end
    end

    // Next state: en low restarts at LOAD, otherwise count up and park in HOLD.
    always_comb begin
        pc_next = pc;
        if (!bus.en) begin
            pc_next = PC_LOAD;
        end else if (pc != PC_HOLD) begin
            pc_next = pc + PC_W'(1);
        end
    end

    // Output decode: which datapath action happens at the coming edge.
    always_comb begin
        do_load = 1'b0;
        do_iter = 1'b0;
        do_sign = 1'b0;
        if (bus.en) begin
            do_load = (pc == PC_LOAD);
            do_iter = (pc != PC_LOAD) && (pc <= PC_LAST_ITER);
            do_sign = (pc == PC_SIGN);
        end
    end

    // Operand conditioning: signed mode works on magnitudes and remembers the sign.
    // The most negative value negates to itself, which is its correct unsigned magnitude.
    always_comb begin
        a_mag_in   = bus.multiplicand;
        b_mag_in   = bus.multiplier;
        neg_res_in = 1'b0;
        if (bus.sign) begin
            if (bus.multiplicand[DATA_W-1]) begin
                a_mag_in = -bus.multiplicand;
            end
            if (bus.multiplier[DATA_W-1]) begin
                b_mag_in = -bus.multiplier;
            end
            neg_res_in = bus.multiplicand[DATA_W-1] ^ bus.multiplier[DATA_W-1];
        end
    end

    // One partial-product step: conditional add into hi, then shift the whole acc right.
    always_comb begin
        hi_sum = acc[ACC_W-1:DATA_W];
        if (acc[0]) begin
            hi_sum = acc[ACC_W-1:DATA_W] + {1'b0, a_mag};
        end
        acc_step = {1'b0, hi_sum, acc[DATA_W-1:1]};
    end

    // Final sign fix-up; a zero magnitude negates to zero so no negative zero appears.
    always_comb begin
        acc_lo      = acc[2*DATA_W-1:0];
        product_fix = acc_lo;
        if (neg_res) begin
            product_fix = -acc_lo;
        end
    end

    // Datapath registers: load, iterate, publish the product, clear when en drops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_mag     <= '0;
            neg_res   <= 1'b0;
            acc       <= '0;
            product_r <= '0;
            done_r    <= 1'b0;
        end else if (!bus.en) begin
            acc       <= '0;
            product_r <= '0;
            done_r    <= 1'b0;
        end else begin
            if (do_load) begin
                a_mag   <= a_mag_in;
                neg_res <= neg_res_in;
                acc     <= {{(DATA_W + 1){1'b0}}, b_mag_in};
            end
            if (do_iter) begin
                acc <= acc_step;
            end
            if (do_sign) begin
                product_r <= product_fix;
                done_r    <= 1'b1;
            end
        end
    end

    assign bus.done    = done_r;
    assign bus.product = product_r;
endmodule

// File: tb/tb_mul_shiftadd.sv
// tb/tb_mul_shiftadd.sv - self-checking bench for mul_shiftadd
module tb_mul_shiftadd;
    localparam int W = 8;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_errors;
    logic chk_on;

    mul_shiftadd_if #(.DATA_W(W)) bus ();

    mul_shiftadd #(.DATA_W(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference product straight from integer arithmetic.
    function automatic logic [2*W-1:0] ref_mul(input bit s, input logic [W-1:0] a,
                                               input logic [W-1:0] b);
        longint pa;
        longint pb;
        longint p;
        if (s) begin
            pa = longint'($signed(a));
            pb = longint'($signed(b));
        end else begin
            pa = longint'(a);
            pb = longint'(b);
        end
        p = pa * pb;
        return p[2*W-1:0];
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: count edges with en high since en was last low, capture operands on the first.
    int               m_cnt;
    logic [2*W-1:0]   m_prod;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_cnt <= 0;
        end else if (!bus.en) begin
            m_cnt <= 0;
        end else begin
            if (m_cnt == 0) m_prod <= ref_mul(bus.sign, bus.multiplicand, bus.multiplier);
            if (m_cnt < W + 2) m_cnt <= m_cnt + 1;
        end
    end

    // Every falling edge: done and product must match the model.
    logic           exp_done;
    logic [2*W-1:0] exp_prod;
    always @(negedge clk) begin
        if (chk_on) begin
            exp_done = rst_n && (m_cnt >= W + 2);
            exp_prod = exp_done ? m_prod : '0;
            check("model done", 64'(bus.done), 64'(exp_done));
            check("model product", 64'(bus.product), 64'(exp_prod));
        end
    end

    task automatic run_op(input bit s, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [2*W-1:0] exp, input string name);
        int edges;
        @(negedge clk);
        bus.en = 1'b0;
        @(negedge clk);
        bus.sign = s;
        bus.multiplicand = a;
        bus.multiplier = b;
        bus.en = 1'b1;
        edges = 0;
        while (edges < 30) begin
            @(posedge clk);
            edges++;
            #1;
            if (edges == 1) begin
                bus.multiplicand = ~a;
                bus.multiplier = a ^ b ^ 8'h5A;
                bus.sign = ~s;
            end
            if (bus.done) break;
        end
        check({name, " latency"}, 64'(edges), 64'(W + 2));
        check({name, " product"}, 64'(bus.product), 64'(exp));
        repeat (3) @(posedge clk);
        #1;
        check({name, " hold done"}, 64'(bus.done), 64'd1);
        check({name, " hold product"}, 64'(bus.product), 64'(exp));
    endtask

    logic [W-1:0] ra;
    logic [W-1:0] rb;
    bit           rs;

    function automatic logic [W-1:0] pick_operand();
        logic [W-1:0] v;
        case ($urandom_range(0, 7))
            0: v = 8'h00;
            1: v = 8'h01;
            2: v = 8'h7F;
            3: v = 8'h80;
            4: v = 8'hFF;
            default: v = W'($urandom);
        endcase
        return v;
    endfunction

    initial begin
        n_checks = 0;
        n_errors = 0;
        chk_on = 1'b0;
        rst_n = 1'b0;
        bus.en = 1'b0;
        bus.sign = 1'b0;
        bus.multiplicand = '0;
        bus.multiplier = '0;
        #2;
        check("reset done", 64'(bus.done), 64'd0);
        check("reset product", 64'(bus.product), 64'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        chk_on = 1'b1;

        run_op(1'b0, 8'd7, 8'd9, 16'h003F, "u 7*9");
        run_op(1'b1, 8'hFD, 8'h05, 16'hFFF1, "s -3*5");
        run_op(1'b1, 8'hF9, 8'hFA, 16'h002A, "s -7*-6");
        run_op(1'b1, 8'h80, 8'h80, 16'h4000, "s min*min");
        run_op(1'b0, 8'hFF, 8'hFF, 16'hFE01, "u max*max");
        run_op(1'b0, 8'hFD, 8'h05, 16'h04F1, "u FD*05");
        run_op(1'b1, 8'h00, 8'h80, 16'h0000, "s 0*min");
        run_op(1'b1, 8'hFF, 8'h00, 16'h0000, "s -1*0");

        // Abort mid-operation, then restart with fresh operands.
        @(negedge clk);
        bus.en = 1'b0;
        @(negedge clk);
        bus.sign = 1'b0;
        bus.multiplicand = 8'h12;
        bus.multiplier = 8'h34;
        bus.en = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        bus.en = 1'b0;
        @(posedge clk);
        #1;
        check("abort done", 64'(bus.done), 64'd0);
        check("abort product", 64'(bus.product), 64'd0);
        run_op(1'b0, 8'd3, 8'd4, 16'h000C, "restart 3*4");

        // Asynchronous reset while the result is being held.
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("async rst hold done", 64'(bus.done), 64'd0);
        check("async rst hold product", 64'(bus.product), 64'd0);
        bus.en = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        run_op(1'b0, 8'd7, 8'd9, 16'h003F, "after rst 7*9");

        // Asynchronous reset in the middle of an operation.
        @(negedge clk);
        bus.en = 1'b0;
        @(negedge clk);
        bus.en = 1'b1;
        repeat (4) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("async rst mid done", 64'(bus.done), 64'd0);
        check("async rst mid product", 64'(bus.product), 64'd0);
        bus.en = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        run_op(1'b1, 8'hFD, 8'h05, 16'hFFF1, "after rst -3*5");

        for (int i = 0; i < 300; i++) begin
            rs = 1'($urandom);
            ra = pick_operand();
            rb = pick_operand();
            run_op(rs, ra, rb, ref_mul(rs, ra, rb), "random");
        end

        @(negedge clk);
        bus.en = 1'b0;
        @(negedge clk);
        chk_on = 1'b0;
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
